// File: rtl/mmm_pkg.sv
// mmm_pkg: shared definitions for the Montgomery result collector.
//   DwDefault - default operand/result width in bits
//   WDefault  - default processing-element word width in bits
//   calc_nw   - number of S words per result (dw/w + 1)
//   state_e   - collector FSM states
package mmm_pkg;

   localparam int unsigned DwDefault = 12;
   localparam int unsigned WDefault  = 6;

   // The PE chain emits one guard word above the dw-bit result.
   function automatic int unsigned calc_nw(input int unsigned dw, input int unsigned w);
      return dw / w + 1;
   endfunction

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StSelect,
      StDone
   } state_e;

endpackage

// File: rtl/mmm_sub_word.sv
// mmm_sub_word: one w-bit word of a word-serial subtraction, d = a - b - bin.
// Ports:
//   a, b  - minuend and subtrahend words
//   bin   - borrow in from the next-lower word
//   d     - difference word
//   bout  - borrow out to the next-higher word
module mmm_sub_word
   import mmm_pkg::*;
#(
   parameter int unsigned w = WDefault
) (
   input  logic [w-1:0] a,
   input  logic [w-1:0] b,
   input  logic         bin,
   output logic [w-1:0] d,
   output logic         bout
);

   logic [w:0] diff;

   // The extra top bit of the widened difference is the borrow.
   assign diff = {1'b0, a} - {1'b0, b} - {{w{1'b0}}, bin};
   assign d    = diff[w-1:0];
   assign bout = diff[w];

endmodule

// File: rtl/mmm_result_collector.sv
// mmm_result_collector: gathers the NW S words (LSW first) from the last PE,
// optionally performs the final conditional subtraction S - M, and presents
// the dw-bit Montgomery product with a one-cycle done pulse.
// Build option: define MMM_FINAL_SUB_EN to compile in the word-serial
// subtractor and the S >= M selection; otherwise result is always S.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   s_valid - s_word/m_word carry a valid pair
//   s_word  - S word from the last PE
//   m_word  - modulus word with the same index
//   s_last  - final word pair of a result
//   s_ready - a pair is accepted this cycle when s_valid is also high
//   result  - reduced product, held between done pulses
//   done    - one-cycle pulse, result is new
//   err     - one-cycle pulse, framing error (frame dropped)
//   busy    - FSM not idle
module mmm_result_collector
   import mmm_pkg::*;
#(
   parameter int unsigned dw = DwDefault,
   parameter int unsigned w  = WDefault
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   input  logic [w-1:0]  s_word,
   input  logic [w-1:0]  m_word,
   input  logic          s_last,
   output logic          s_ready,
   output logic [dw-1:0] result,
   output logic          done,
   output logic          err,
   output logic          busy
);

   localparam int unsigned NW   = calc_nw(dw, w);
   localparam int unsigned IdxW = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NW - 1);

   state_e                 state_q, state_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [NW-1:0][w-1:0]   s_buf_q;
   logic [NW*w-1:0]        s_flat;
   logic [dw-1:0]          result_q;
   logic [dw-1:0]          sel_result;
   logic                   err_q, err_d;
   logic                   accept, at_last, frame_err;

   assign s_ready   = (state_q == StIdle) || (state_q == StCollect);
   assign accept    = s_valid && s_ready;
   assign at_last   = (idx_q == IdxLast);
   // s_last must coincide exactly with the final word index.
   assign frame_err = accept && (at_last != s_last);
   assign s_flat    = s_buf_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle, StCollect: begin
            if (frame_err) begin
               state_d = StIdle;
               idx_d   = '0;
               err_d   = 1'b1;
            end else if (accept) begin
               if (at_last) begin
                  state_d = StSelect;
               end else begin
                  state_d = StCollect;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         StSelect: state_d = StDone;
         StDone: begin
            state_d = StIdle;
            idx_d   = '0;
         end
         default: begin
            state_d = StIdle;
            idx_d   = '0;
         end
      endcase
   end

`ifdef MMM_FINAL_SUB_EN
   logic                 borrow_q;
   logic                 sub_bin, sub_bout;
   logic [w-1:0]         sub_d;
   logic [NW-1:0][w-1:0] d_buf_q;
   logic [NW*w-1:0]      d_flat;
   logic                 unused_d_hi;

   // The borrow chain restarts at the least-significant word.
   assign sub_bin = (idx_q == '0) ? 1'b0 : borrow_q;

   mmm_sub_word #(
      .w (w)
   ) u_sub_word (
      .a    (s_word),
      .b    (m_word),
      .bin  (sub_bin),
      .d    (sub_d),
      .bout (sub_bout)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         borrow_q <= 1'b0;
         d_buf_q  <= '0;
      end else if (frame_err) begin
         borrow_q <= 1'b0;
         d_buf_q  <= '0;
      end else if (accept) begin
         borrow_q       <= sub_bout;
         d_buf_q[idx_q] <= sub_d;
      end
   end

   assign d_flat      = d_buf_q;
   // Final borrow clear means S >= M, so the reduced value is D.
   assign sel_result  = borrow_q ? s_flat[dw-1:0] : d_flat[dw-1:0];
   assign unused_d_hi = ^d_flat[NW*w-1:dw];
`else
   logic unused_m;

   assign sel_result = s_flat[dw-1:0];
   assign unused_m   = ^m_word;
`endif

   // Guard bits above dw only feed the subtraction.
   logic unused_s_hi;
   assign unused_s_hi = ^s_flat[NW*w-1:dw];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         s_buf_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         if (frame_err) begin
            s_buf_q <= '0;
         end else if (accept) begin
            s_buf_q[idx_q] <= s_word;
         end
         if (state_q == StSelect) begin
            result_q <= sel_result;
         end
      end
   end

   assign result = result_q;
   assign done   = (state_q == StDone);
   assign err    = err_q;
   assign busy   = (state_q != StIdle);

endmodule

// File: doc/mmm_result_collector.md
MMM_RESULT_COLLECTOR -- requirements
Module: mmm_result_collector

Interface
REQ-001 The module SHALL have parameter dw, default 12, giving the operand and result width in bits.
REQ-002 The module SHALL have parameter w, default 6, giving the word width of the processing-element chain.
REQ-003 The module SHALL use derived constant NW = dw/w + 1 as the number of S words per result (3 at defaults).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port s_valid, input, 1 bit: s_word and m_word carry a valid word pair.
REQ-007 The module SHALL have port s_word, input, w bits: S word from the last PE, least-significant word first.
REQ-008 The module SHALL have port m_word, input, w bits: modulus word with the same index as s_word.
REQ-009 The module SHALL have port s_last, input, 1 bit: marks the final word pair of a result.
REQ-010 The module SHALL have port s_ready, output, 1 bit: the collector accepts a word pair this cycle.
REQ-011 The module SHALL have port result, output, dw bits: the reduced Montgomery product.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle pulse marking result as new.
REQ-013 The module SHALL have port err, output, 1 bit: one-cycle pulse on a framing error.
REQ-014 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 A word pair SHALL be accepted only in a cycle where s_valid and s_ready are both 1.
REQ-016 s_ready SHALL be 1 in IDLE and COLLECT, and 0 in SELECT and DONE.
REQ-017 The FSM SHALL have states IDLE, COLLECT, SELECT and DONE.
REQ-018 IDLE SHALL go to COLLECT on acceptance of the first word pair; that word is stored at index 0.
REQ-019 COLLECT SHALL store each accepted word at the current index and then increment the index.
REQ-020 The index SHALL be 0 to NW-1, clear to 0 on entry to IDLE, and never wrap while collecting.
REQ-021 Each accepted pair SHALL be subtracted word-serially (D_j = S_j - M_j - borrow_in), with the borrow registered between words and cleared at index 0.
REQ-022 s_last accepted at index NW-1 SHALL move the FSM to SELECT.
REQ-023 s_last at any index other than NW-1, or an accepted word at index NW-1 without s_last, SHALL pulse err, discard the buffer and return the FSM to IDLE, with no done pulse.
REQ-024 SELECT SHALL set result to the low dw bits of D if the final borrow is 0 (S >= M), otherwise to the low dw bits of S, and then go to DONE.
REQ-025 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-026 Latency from acceptance of the last word to done SHALL be exactly 2 cycles.
REQ-027 result SHALL hold its value from one done pulse until the next.
REQ-028 An s_valid arriving in SELECT or DONE SHALL not be accepted, and the sender SHALL hold the word.
REQ-029 Words of S above bit dw-1 SHALL be used by the subtraction but dropped from result.

Reset
REQ-030 On rst low, asynchronously: FSM to IDLE; index, borrow and the S/D buffers to 0; result to 0; done, err and busy to 0.
REQ-031 On rst low, s_ready SHALL be 1 once rst is deasserted.
REQ-032 Reset asserted mid-collection SHALL abandon the partial result with no done or err pulse.

Configuration
REQ-033 With macro MMM_FINAL_SUB_EN defined, the subtractor and the SELECT decision SHALL be compiled in as described in REQ-021 and REQ-024.
REQ-034 Without MMM_FINAL_SUB_EN, the D buffer and subtractor SHALL be absent and SELECT SHALL always output S; latency is unchanged.

Structure
REQ-035 The shared package mmm_pkg SHALL hold the default dw and w, the NW function, and the FSM state enum.
REQ-036 A single sub-module, mmm_sub_word, SHALL implement the w-bit subtract-with-borrow (inputs a, b, bin; outputs d, bout).

Verification (dw=12, w=6)
REQ-037 Send S=3000 (words 56,46,0) and M=2867 (words 51,44,0), s_valid continuous -> done 2 cycles after the third word, result=133, err=0.
REQ-038 Send S=100 (words 36,1,0) and M=2867 -> result=100.
REQ-039 Send S=2867 equal to M -> result=0 (boundary: borrow 0).
REQ-040 Send s_last with the second word -> err pulse that cycle, no done, busy=0 next cycle, and a following valid frame is processed correctly.
REQ-041 Assert rst after the second word, then send a full frame -> no stale data, correct result, exactly one done pulse.
REQ-042 Hold s_valid high through SELECT/DONE with the next frame's first word -> that word is not accepted until IDLE, and back-to-back frames yield correct results.
